mem_rd_ctr_b: RTL and testbench
===============================

// Module: mem_rd_ctr_B
// PURPOSE
//  Read-side controller for the frame BRAM. After the upstream writer has filled
//  the frame through port A, a start pulse makes this block sweep port B from
//  address 0 to MAX_ROW*MAX_COL-1. It streams the pixels downstream on a
//  valid/ready interface with row and frame markers, and absorbs BRAM read
//  latency and backpressure in an internal skid FIFO.
// PARAMETERS
//  MAX_ROW   360  frame height in lines
//  MAX_COL   540  frame width in pixels; MAX_ROW*MAX_COL <= 2^18
//  RD_LAT    1    BRAM port-B read latency in cycles (1 or 2)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous active-low reset
//  enb_o        out  1   BRAM port-B enable; one read is issued per cycle while high
//  web_o        out  1   BRAM port-B write enable; tied to 0 (read only)
//  addrb_o      out  18  BRAM port-B address
//  d2memb_o     out  8   BRAM port-B write data; tied to 0
//  mem2db_i     in   8   BRAM port-B read data; valid RD_LAT cycles after enb_o
//  start_i      in   1   one-cycle pulse: the frame in BRAM is complete, begin readout
//  busy_o       out  1   high from the cycle after an accepted start until done_o
//  done_o       out  1   one-cycle pulse in the cycle after the last pixel handshake
//  pixel_o      out  8   output pixel
//  pixel_vld_o  out  1   pixel_o is valid
//  pixel_rdy_i  in   1   downstream accepts; a transfer occurs when vld & rdy
//  sol_o        out  1   qualifies pixel_o: first pixel of a line (col 0)
//  eol_o        out  1   qualifies pixel_o: last pixel of a line (col MAX_COL-1)
//  eof_o        out  1   qualifies pixel_o: last pixel of the frame
// BEHAVIOUR
//  - Reset values: all outputs are 0; FSM=IDLE; address, row/col, in-flight
//    and FIFO counters are 0. web_o and d2memb_o stay 0 at all times.
//  - FSM IDLE: start_i=1 -> READ. start_i is ignored in READ, DRAIN and DONE.
//  - FSM READ: issue a read (enb_o=1, addrb_o=rd_addr, then rd_addr+1) only when
//    fifo_cnt + inflight < FIFO_DEPTH, where FIFO_DEPTH = RD_LAT+2.
//    Move to DRAIN in the cycle after the read of address N-1 is issued
//    (N = MAX_ROW*MAX_COL).
//  - FSM DRAIN: no reads are issued. Move to DONE when the handshake of the
//    pixel with eof_o completes.
//  - FSM DONE: done_o=1 for this single cycle; rd_addr is cleared to 0; go to IDLE.
//  - Read pipeline: a shift register of RD_LAT enable bits tracks reads in flight.
//    When the tagged slot emerges, mem2db_i is pushed into the FIFO.
//  - The FIFO is show-ahead. pixel_vld_o = (fifo_cnt != 0), and pixel_o is the
//    head entry. A push and a pop in the same cycle are both allowed; the count
//    does not change.
//  - The credit rule must make FIFO overflow impossible. An overflow is a design
//    error, and the bench must assert on it.
//  - Latency: start_i at cycle 0 gives enb_o=1 with addrb_o=0 at cycle 1, and
//    pixel_vld_o=1 with pixel 0 at cycle 2+RD_LAT.
//  - Throughput: with pixel_rdy_i held at 1, exactly one pixel per cycle is
//    sustained with no bubbles after the first.
//  - Backpressure: while pixel_rdy_i=0, pixel_o and the marker outputs hold
//    stable and pixel_vld_o stays high. Issuing stops once credits run out.
//  - Markers: the output-side col/row counters advance on each handshake.
//    col wraps MAX_COL-1 -> 0 and increments row. eof_o = eol_o & (row == MAX_ROW-1).
//    The counters clear to 0 after the eof handshake.
//  - Address: it is 18 bits wide and never exceeds N-1. It does not wrap
//    mid-frame, and restarts at 0 for each frame.
//  - Reset mid-frame: all state returns to the reset values immediately.
//    In-flight BRAM data arriving after reset release is discarded, because the
//    pipeline tags were cleared.
//  - Back-to-back frames: a start_i pulse in the cycle done_o is high is ignored.
//    The first start accepted is one arriving in IDLE, at the earliest the cycle
//    after done_o.
// TESTING
//  - Reset -> every output is 0. Apply no start for 20 cycles -> enb_o stays 0 and
//    pixel_vld_o stays 0.
//  - MAX_ROW=3, MAX_COL=4, RD_LAT=1, rdy=1, BRAM preloaded with data = addr ->
//    12 pixels 0..11 arrive on consecutive cycles starting at cycle 3.
//    sol_o on pixels 0,4,8; eol_o on pixels 3,7,11; eof_o on pixel 11 only.
//    done_o pulses at cycle 15.
//  - Same frame with RD_LAT=2 and rdy toggling randomly -> an identical pixel
//    sequence, no drops or duplicates, and never more than 4 FIFO entries.
//  - rdy=0 for 10 cycles mid-frame -> pixel_o, eol_o and the other markers stay
//    stable. enb_o goes low after the credits are used. Full rate resumes when
//    rdy returns to 1.
//  - Extra start_i pulses during READ and DRAIN -> ignored; exactly one frame is
//    output.
//  - rst_n asserted at pixel 5 of 12, then a new start -> the output begins again
//    at pixel 0 with sol_o=1, and no stale data appears.

Source files
------------

// File: rtl/mem_rd_ctr_b.sv
// Frame BRAM read-side controller: sweeps port B after a start pulse and
// streams pixels with sol/eol/eof markers through a credit-guarded skid FIFO.
module mem_rd_ctr_b #(
    parameter int MAX_ROW = 360,
    parameter int MAX_COL = 540,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        enb_o,
    output logic        web_o,
    output logic [17:0] addrb_o,
    output logic [7:0]  d2memb_o,
    input  logic [7:0]  mem2db_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  pixel_o,
    output logic        pixel_vld_o,
    input  logic        pixel_rdy_i,
    output logic        sol_o,
    output logic        eol_o,
    output logic        eof_o
);

    localparam int N     = MAX_ROW * MAX_COL;
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int XW    = $clog2(MAX_COL + 1);
    localparam int YW    = $clog2(MAX_ROW + 1);

    localparam logic [17:0]   LAST_ADDR = 18'(N - 1);
    localparam logic [XW-1:0] COL_LAST  = XW'(MAX_COL - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(MAX_ROW - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [17:0]     rd_addr;
    logic [RD_LAT-1:0] tag_q;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [7:0]      fifo_mem [DEPTH];
    logic [XW-1:0]   col;
    logic [YW-1:0]   row;
    logic            credit;
    logic            issue;
    logic            push;
    logic            pop;
    logic            last_hs;

    // Reads in flight plus queued pixels never exceed the FIFO depth.
    assign credit  = ({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_C;
    assign issue   = (state == READ) && credit;
    assign push    = tag_q[RD_LAT-1];
    assign pop     = pixel_vld_o && pixel_rdy_i;
    assign last_hs = pop && eof_o;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_i) state_nxt = READ;
            READ:    if (issue && rd_addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   if (last_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (state == DONE) begin
            rd_addr <= '0;
        end else if (issue && rd_addr != LAST_ADDR) begin
            rd_addr <= rd_addr + 18'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            inflight <= '0;
        end else begin
            tag_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            unique case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem2db_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Output-side position; it follows handshakes, not reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pop) begin
            if (eof_o) begin
                col <= '0;
                row <= '0;
            end else if (col == COL_LAST) begin
                col <= '0;
                row <= row + YW'(1);
            end else begin
                col <= col + XW'(1);
            end
        end
    end

    assign enb_o       = issue;
    assign web_o       = 1'b0;
    assign d2memb_o    = 8'h00;
    assign addrb_o     = rd_addr;
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign pixel_vld_o = (fifo_cnt != '0);
    assign pixel_o     = pixel_vld_o ? fifo_mem[rd_ptr] : 8'h00;
    assign sol_o       = pixel_vld_o && (col == '0);
    assign eol_o       = pixel_vld_o && (col == COL_LAST);
    assign eof_o       = eol_o && (row == ROW_LAST);

endmodule

// File: tb/tb_mem_rd_ctr_b.sv
// Bench for mem_rd_ctr_b: 3x4 frames at read latency 1 and 2, checked
// against a pixel-order and marker model built from frame geometry.
module tb_mem_rd_ctr_b;

    localparam int R = 3;
    localparam int C = 4;
    localparam int N = R * C;

    logic        clk;
    logic        rst_n;
    logic [1:0]  start, rdy, enb, web, busy, done, vld, sol, eol, eof;
    logic [17:0] addr [2];
    logic [7:0]  d2m  [2];
    logic [7:0]  din  [2];
    logic [7:0]  pix  [2];
    logic [7:0]  bram [2][N];
    logic [7:0]  q0, q1a, q1b;

    int checks, errors;
    int k [2], issued [2], popped [2];
    int done_cnt [2], done_cyc [2], first_hs [2], last_hs [2];
    int rogue;
    bit held [2];
    logic [7:0] h_pix [2];
    logic [2:0] h_mk [2];

    mem_rd_ctr_b #(.MAX_ROW(R), .MAX_COL(C), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .enb_o(enb[0]), .web_o(web[0]), .addrb_o(addr[0]),
        .d2memb_o(d2m[0]), .mem2db_i(din[0]),
        .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .pixel_o(pix[0]), .pixel_vld_o(vld[0]), .pixel_rdy_i(rdy[0]),
        .sol_o(sol[0]), .eol_o(eol[0]), .eof_o(eof[0])
    );

    mem_rd_ctr_b #(.MAX_ROW(R), .MAX_COL(C), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .enb_o(enb[1]), .web_o(web[1]), .addrb_o(addr[1]),
        .d2memb_o(d2m[1]), .mem2db_i(din[1]),
        .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .pixel_o(pix[1]), .pixel_vld_o(vld[1]), .pixel_rdy_i(rdy[1]),
        .sol_o(sol[1]), .eol_o(eol[1]), .eof_o(eof[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd_bram(input int d, input logic [17:0] a);
        if (a < 18'(N)) return bram[d][int'(a)];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (enb[0]) q0 <= rd_bram(0, addr[0]);
        if (enb[1]) q1a <= rd_bram(1, addr[1]);
        q1b <= q1a;
    end

    assign din[0] = q0;
    assign din[1] = q1b;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk(tag, {enb[d], web[d], busy[d], done[d],
                      vld[d], sol[d], eol[d], eof[d]}, 0);
            chk(tag, addr[d], 0);
            chk(tag, pix[d], 0);
            chk(tag, d2m[d], 0);
        end
    endtask

    task automatic sb_clear(input int d);
        k[d] = 0;
        issued[d] = 0;
        popped[d] = 0;
        done_cnt[d] = 0;
        done_cyc[d] = -1;
        first_hs[d] = -1;
        last_hs[d] = -1;
        held[d] = 1'b0;
    endtask

    task automatic tick(input int d, input bit st, input bit r, input int c);
        @(negedge clk);
        start = 2'b00;
        rdy = 2'b00;
        start[d] = st;
        rdy[d] = r;
        #1;
        if (enb[d]) begin
            issued[d]++;
            chk("credit", (issued[d] - popped[d]) <= (d == 0 ? 3 : 4), 1);
        end
        if (held[d]) begin
            chk("hold_vld", vld[d], 1);
            chk("hold_pix", pix[d], h_pix[d]);
            chk("hold_mk", {sol[d], eol[d], eof[d]}, h_mk[d]);
        end
        held[d] = vld[d] && !r;
        h_pix[d] = pix[d];
        h_mk[d] = {sol[d], eol[d], eof[d]};
        if (vld[d] && r) begin
            chk("extra_px", k[d] < N, 1);
            if (k[d] < N) begin
                chk("pixel", pix[d], bram[d][k[d]]);
                chk("sol", sol[d], (k[d] % C) == 0);
                chk("eol", eol[d], (k[d] % C) == C - 1);
                chk("eof", eof[d], k[d] == N - 1);
            end
            if (first_hs[d] < 0) first_hs[d] = c;
            last_hs[d] = c;
            k[d]++;
            popped[d]++;
        end
        if (done[d]) begin
            done_cnt[d]++;
            done_cyc[d] = c;
        end
    endtask

    // mode 0: rdy=1; 1: rdy low for cycles 6..15; 2: stray starts; 3: random rdy
    task automatic run(input int d, input int ncyc, input int mode);
        bit st;
        bit r;
        sb_clear(d);
        rogue = 0;
        tick(d, 1'b1, 1'b1, 0);
        for (int c = 1; c < ncyc; c++) begin
            st = 1'b0;
            r = 1'b1;
            if (mode == 1) r = !(c >= 6 && c <= 15);
            if (mode == 2) st = (c == 5 || c == 13 || c == 15);
            if (mode == 3 && c > 4) r = 1'($urandom_range(0, 1));
            tick(d, st, r, c);
            if (c == 1) begin
                chk("lat_enb", enb[d], 1);
                chk("lat_addr", addr[d], 0);
                chk("lat_busy", busy[d], 1);
            end
            if (mode == 1 && c == 15) chk("stall_enb", enb[d], 0);
            if (done_cyc[d] >= 0 && c > done_cyc[d] && enb[d]) rogue++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 2'b00;
        rdy = 2'b00;
        for (int i = 0; i < N; i++) begin
            bram[0][i] = 8'(i);
            bram[1][i] = 8'(i);
        end

        repeat (2) @(negedge clk);
        #1;
        chk_zero("rst_outs");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("idle_enb", enb, 0);
            chk("idle_vld", vld, 0);
        end
        chk_zero("idle_outs");

        // full rate, data = address
        run(0, 30, 0);
        chk("A_first", first_hs[0], 3);
        chk("A_last", last_hs[0], 14);
        chk("A_count", k[0], N);
        chk("A_done_n", done_cnt[0], 1);
        chk("A_done_cyc", done_cyc[0], 15);

        // ten-cycle stall mid-frame
        for (int i = 0; i < N; i++) bram[0][i] = 8'(8'h40 + i);
        run(0, 40, 1);
        chk("B_first", first_hs[0], 3);
        chk("B_last", last_hs[0], 24);
        chk("B_count", k[0], N);
        chk("B_done_n", done_cnt[0], 1);
        chk("B_done_cyc", done_cyc[0], 25);

        // stray starts in READ, DRAIN and DONE
        for (int i = 0; i < N; i++) bram[0][i] = 8'(8'h80 + i);
        run(0, 35, 2);
        chk("C_last", last_hs[0], 14);
        chk("C_count", k[0], N);
        chk("C_done_n", done_cnt[0], 1);
        chk("C_done_cyc", done_cyc[0], 15);
        chk("C_rogue", rogue, 0);
        chk("C_busy", busy[0], 0);

        // reset at pixel 5, then a fresh frame with new contents
        for (int i = 0; i < N; i++) bram[0][i] = 8'(8'h10 + i);
        sb_clear(0);
        tick(0, 1'b1, 1'b1, 0);
        for (int c = 1; c <= 8; c++) tick(0, 1'b0, 1'b1, c);
        chk("D_pre_count", k[0], 6);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) bram[0][i] = 8'(8'hC0 + i);
        sb_clear(0);
        for (int c = 0; c < 4; c++) begin
            tick(0, 1'b0, 1'b1, c);
            chk("D_stale_vld", vld[0], 0);
        end
        run(0, 30, 0);
        chk("D_first", first_hs[0], 3);
        chk("D_last", last_hs[0], 14);
        chk("D_count", k[0], N);
        chk("D_done_cyc", done_cyc[0], 15);

        // read latency 2, full rate
        for (int i = 0; i < N; i++) bram[1][i] = 8'($urandom);
        run(1, 30, 0);
        chk("E_first", first_hs[1], 4);
        chk("E_last", last_hs[1], 15);
        chk("E_count", k[1], N);
        chk("E_done_cyc", done_cyc[1], 16);

        // read latency 2, random backpressure
        for (int i = 0; i < N; i++) bram[1][i] = 8'($urandom);
        run(1, 300, 3);
        chk("F_first", first_hs[1], 4);
        chk("F_count", k[1], N);
        chk("F_done_n", done_cnt[1], 1);
        chk("F_rogue", rogue, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
